// File: rtl/gbf_read_scheduler.sv
// Round-robin read scheduler for one global-buffer RAM read port.
// A granted requester owns the port for a burst of consecutive addresses.
// Returning data is tagged with the owner, and done pulses on the last word.
module gbf_read_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned HEIGHT  = 32,
  parameter int unsigned AW      = $clog2(HEIGHT),
  parameter int unsigned LW      = 4,
  localparam int unsigned SW     = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*LW-1:0] req_len,
  output logic [NUM_REQ-1:0]    grant,
  output logic [SW-1:0]         select,
  output logic                  rd_en,
  output logic [AW-1:0]         ram_addr,
  output logic                  data_valid,
  output logic [NUM_REQ-1:0]    data_owner,
  output logic [NUM_REQ-1:0]    done,
  output logic                  busy
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [SW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SW-1:0]      select_q, select_d;
  logic               rd_en_q, rd_en_d;
  logic [AW-1:0]      ram_addr_q, ram_addr_d;
  logic [LW-1:0]      remaining_q, remaining_d;
  logic               data_valid_q, data_valid_d;
  logic [NUM_REQ-1:0] data_owner_q, data_owner_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;

  logic [AW-1:0] addr_arr [NUM_REQ];
  logic [LW-1:0] len_arr  [NUM_REQ];

  logic          win_found;
  logic [SW-1:0] win_idx;

  // Unpack the per-requester address and length fields.
  for (genvar n = 0; n < NUM_REQ; n++) begin : g_unpack
    assign addr_arr[n] = req_addr[n*AW +: AW];
    assign len_arr[n]  = req_len[n*LW +: LW];
  end

  // Round-robin search: first set request bit at or above rr_ptr, wrapping.
  always_comb begin
    int unsigned idx;
    logic [SW-1:0] idx_sw;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    idx_sw    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      idx_sw = SW'(idx);
      if (!win_found && req[idx_sw]) begin
        win_found = 1'b1;
        win_idx   = idx_sw;
      end
    end
  end

  // Next-state logic for the burst FSM and all registered outputs.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    select_d     = select_q;
    rd_en_d      = rd_en_q;
    ram_addr_d   = ram_addr_q;
    remaining_d  = remaining_q;
    busy_d       = busy_q;
    // Read data returns one cycle after the address, owned by the current grant.
    data_valid_d = rd_en_q;
    data_owner_d = rd_en_q ? grant_q : '0;
    done_d       = '0;

    unique case (state_q)
      StIdle: begin
        if (en && win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          select_d         = win_idx;
          ram_addr_d       = addr_arr[win_idx];
          rd_en_d          = 1'b1;
          busy_d           = 1'b1;
          // Zero length is served as a single-word burst.
          remaining_d      = (len_arr[win_idx] == '0) ? LW'(1) : len_arr[win_idx];
          state_d          = StIssue;
        end
      end
      StIssue: begin
        if (remaining_q == LW'(1)) begin
          rd_en_d = 1'b0;
          // The last word lands in DRAIN, so done rides along with it.
          done_d  = grant_q;
          state_d = StDrain;
        end else begin
          remaining_d = remaining_q - LW'(1);
          ram_addr_d  = (ram_addr_q == AW'(HEIGHT - 1)) ? '0 : ram_addr_q + AW'(1);
        end
      end
      StDrain: begin
        grant_d  = '0;
        select_d = '0;
        busy_d   = 1'b0;
        rr_ptr_d = (select_q == SW'(NUM_REQ - 1)) ? '0 : select_q + SW'(1);
        state_d  = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset aborts any burst and drops in-flight data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      select_q     <= '0;
      rd_en_q      <= 1'b0;
      ram_addr_q   <= '0;
      remaining_q  <= '0;
      data_valid_q <= 1'b0;
      data_owner_q <= '0;
      done_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      select_q     <= select_d;
      rd_en_q      <= rd_en_d;
      ram_addr_q   <= ram_addr_d;
      remaining_q  <= remaining_d;
      data_valid_q <= data_valid_d;
      data_owner_q <= data_owner_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign grant      = grant_q;
  assign select     = select_q;
  assign rd_en      = rd_en_q;
  assign ram_addr   = ram_addr_q;
  assign data_valid = data_valid_q;
  assign data_owner = data_owner_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_gbf_read_scheduler.sv
// Directed bench for gbf_read_scheduler with hand-computed expectations.
module tb_gbf_read_scheduler;

  localparam int NUM_REQ = 4;
  localparam int HEIGHT  = 32;
  localparam int AW      = 5;
  localparam int LW      = 4;
  localparam int SW      = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  en;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*LW-1:0] req_len;
  logic [NUM_REQ-1:0]    grant;
  logic [SW-1:0]         select;
  logic                  rd_en;
  logic [AW-1:0]         ram_addr;
  logic                  data_valid;
  logic [NUM_REQ-1:0]    data_owner;
  logic [NUM_REQ-1:0]    done;
  logic                  busy;

  int n_cmp = 0;
  int n_err = 0;

  gbf_read_scheduler #(
    .NUM_REQ(NUM_REQ),
    .HEIGHT (HEIGHT),
    .AW     (AW),
    .LW     (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .grant     (grant),
    .select    (select),
    .rd_en     (rd_en),
    .ram_addr  (ram_addr),
    .data_valid(data_valid),
    .data_owner(data_owner),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input int a, input int l);
    req_addr[n*AW +: AW] = AW'(a);
    req_len[n*LW +: LW]  = LW'(l);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] oh;
    rst      = 1'b1;
    en       = 1'b0;
    req      = '0;
    req_addr = '0;
    req_len  = '0;
    tick();
    tick();

    // Reset state
    check_eq("rst_grant", grant, 0);
    check_eq("rst_select", select, 0);
    check_eq("rst_rd_en", rd_en, 0);
    check_eq("rst_addr", ram_addr, 0);
    check_eq("rst_dv", data_valid, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_busy", busy, 0);
    rst = 1'b0;

    // Single request: addr 5, len 3
    en  = 1'b1;
    set_req(0, 5, 3);
    req = 4'b0001;
    tick();                                   // cycle 1
    check_eq("s_grant1", grant, 4'b0001);
    check_eq("s_rden1", rd_en, 1);
    check_eq("s_addr1", ram_addr, 5);
    check_eq("s_busy1", busy, 1);
    check_eq("s_dv1", data_valid, 0);
    set_req(0, 20, 9);                        // must be ignored mid-burst
    tick();                                   // cycle 2
    check_eq("s_addr2", ram_addr, 6);
    check_eq("s_dv2", data_valid, 1);
    check_eq("s_owner2", data_owner, 4'b0001);
    tick();                                   // cycle 3
    check_eq("s_addr3", ram_addr, 7);
    check_eq("s_done3", done, 0);
    tick();                                   // cycle 4
    check_eq("s_rden4", rd_en, 0);
    check_eq("s_dv4", data_valid, 1);
    check_eq("s_done4", done, 4'b0001);
    check_eq("s_grant4", grant, 4'b0001);
    req = '0;
    tick();                                   // cycle 5
    check_eq("s_grant5", grant, 0);
    check_eq("s_dv5", data_valid, 0);
    check_eq("s_done5", done, 0);
    check_eq("s_busy5", busy, 0);

    // Simultaneous requests, all len 1: order 0,1,2,3,0
    do_reset();
    for (int n = 0; n < NUM_REQ; n++) set_req(n, n * 4, 1);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      tick();
      check_eq($sformatf("rr_grant%0d", k), grant, oh);
      check_eq($sformatf("rr_sel%0d", k), select, k % 4);
      check_eq($sformatf("rr_addr%0d", k), ram_addr, (k % 4) * 4);
      tick();
      check_eq($sformatf("rr_done%0d", k), done, oh);
      if (k == 4) req = '0;
      tick();
      check_eq($sformatf("rr_idle%0d", k), grant, 0);
    end

    // Pointer fairness: 0 held throughout, 2 arrives mid-burst
    do_reset();
    set_req(0, 10, 2);
    set_req(2, 3, 1);
    req = 4'b0001;
    tick();                                   // ISSUE 1
    check_eq("f_grant0", grant, 4'b0001);
    tick();                                   // ISSUE 2
    req = 4'b0101;
    tick();                                   // DRAIN
    check_eq("f_done0", done, 4'b0001);
    tick();                                   // IDLE
    check_eq("f_idle", grant, 0);
    tick();
    check_eq("f_grant2", grant, 4'b0100);
    check_eq("f_sel2", select, 2);
    tick();
    check_eq("f_done2", done, 4'b0100);
    req = '0;
    tick();

    // Wrap: addr 30, len 4 (rr_ptr=3, only req 0 asks)
    set_req(0, 30, 4);
    req = 4'b0001;
    tick();
    check_eq("w_addr30", ram_addr, 30);
    tick();
    check_eq("w_addr31", ram_addr, 31);
    tick();
    check_eq("w_addr0", ram_addr, 0);
    tick();
    check_eq("w_addr1", ram_addr, 1);
    check_eq("w_done_early", done, 0);
    tick();
    check_eq("w_dv", data_valid, 1);
    check_eq("w_done", done, 4'b0001);
    req = '0;
    tick();
    check_eq("w_dv_end", data_valid, 0);

    // Length zero on requester 1 (rr_ptr=1)
    set_req(1, 9, 0);
    req = 4'b0010;
    tick();
    check_eq("z_rden1", rd_en, 1);
    check_eq("z_addr", ram_addr, 9);
    tick();
    check_eq("z_rden2", rd_en, 0);
    check_eq("z_dv", data_valid, 1);
    check_eq("z_owner", data_owner, 4'b0010);
    check_eq("z_done", done, 4'b0010);
    req = '0;
    tick();
    check_eq("z_dv_end", data_valid, 0);
    check_eq("z_done_end", done, 0);

    // Reset mid-burst: rr_ptr=2 so requester 2 wins first
    set_req(0, 1, 8);
    set_req(2, 16, 8);
    req = 4'b0101;
    tick();                                   // ISSUE 1
    check_eq("r_grant2", grant, 4'b0100);
    tick();                                   // ISSUE 2
    tick();                                   // ISSUE 3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("r_grant", grant, 0);
    check_eq("r_rden", rd_en, 0);
    check_eq("r_dv", data_valid, 0);
    check_eq("r_done", done, 0);
    check_eq("r_busy", busy, 0);
    tick();
    check_eq("r_regrant0", grant, 4'b0001);
    check_eq("r_addr", ram_addr, 1);

    // Enable gate
    req = '0;
    en  = 1'b0;
    do_reset();
    set_req(1, 7, 1);
    req = 4'b0010;
    tick();
    tick();
    check_eq("e_nogrant", grant, 0);
    check_eq("e_norden", rd_en, 0);
    en = 1'b1;
    tick();
    check_eq("e_grant", grant, 4'b0010);
    en = 1'b0;                                // must not disturb the burst
    tick();
    check_eq("e_done", done, 4'b0010);
    req = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
